// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit.
// Holds the size codes, the FSM state enum and the width constants.
// Imported by the top level and by the lane-alignment helper.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_ST_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  // Request cannot be served: illegal size, or half/word not naturally aligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering between a 32-bit memory word and byte/half/word requests.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane (little-endian) and sign/zero-extend it for loads.
  always_comb begin
    byte_v      = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    half_v      = rd_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    load_data_o = rd_word_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SZ_HALF: load_data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: load_data_o = rd_word_i;
    endcase
  end

  // Overlay the store lane onto the word that was read back.
  always_comb begin
    merged_o = rd_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store initiator for a word-wide data memory with combinational read data.
// Latency from acceptance to resp_valid: error 1, load/word store 2, sub-word store 3.
// One request in flight; req_ready is high only while idle.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              bad_d;
  logic [31:0]       load_data_d;
  logic [31:0]       merged_d;

  assign bad_d = req_is_bad(req_size, req_addr[1:0]);

  dmem_lane_align u_lane (
    .addr_lo_i   (addr_lo_q),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .rd_word_i   (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_d),
    .merged_o    (merged_d)
  );

  // Sequencer: strobes and response are registered alongside the state that implies them.
  // The RMW merge is folded into the read cycle, so mem_wdata_q acts as the merge buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_lo_q    <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_lo_q    <= req_addr[1:0];
            size_q       <= req_size;
            unsigned_q   <= req_unsigned;
            wdata_q      <= req_wdata;
            req_ready_q  <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
            if (bad_d) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_write) begin
              state_q    <= S_LD_RD;
              mem_read_q <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_q     <= S_ST_WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= S_RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        S_LD_RD: begin
          resp_rdata_q <= load_data_d;
          mem_read_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_ST_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_RMW_RD: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= merged_d;
          state_q     <= S_RMW_WR;
        end
        S_RMW_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Load/store initiator that drives the word-wide data memory (MemRead/MemWrite/addr/write_data/read_data interface) on behalf of the single-cycle datapath.
- Accepts one byte, halfword or word request at a time.
- Splits sub-word stores into a read-modify-write.
- Aligns and sign- or zero-extends load data.
- Flags misaligned and illegal-size requests without touching memory.

Parameters:
ADDR_W, 8, byte-address width, equal to the memory addr width.
DATA_W, 32, data width; only 32 is supported and the lane logic is hard-wired for it.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  qualified by resp_valid: misaligned or illegal size.
mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 00.
mem_read  out  1  memory read enable.
mem_write  out  1  memory write enable; the memory writes on the next rising clk edge.
mem_wdata  out  32  full word to write.
mem_rdata  in  32  combinational read data; valid in the same cycle mem_read is high.

Behaviour:
Reset:
- State goes to IDLE.
- resp_valid, resp_err, mem_read, mem_write = 0.
- mem_addr, mem_wdata, resp_rdata = 0.
- req_ready = 1.
- All capture registers are cleared.

Acceptance:
- A request is accepted on an edge where req_valid && req_ready.
- addr, size, write, unsigned and wdata are captured at acceptance.
- Request inputs are ignored outside IDLE.

Error check (at acceptance):
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
- Illegal: size 11.
- Either case goes to DONE with err=1. No memory strobe is ever asserted for the request.

FSM states: IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, DONE.
- IDLE -> LD_RD for a load.
- IDLE -> ST_WR for a word store.
- IDLE -> RMW_RD for a byte or half store.
- IDLE -> DONE on error.
- LD_RD: mem_read=1 and mem_addr={addr[7:2],2'b00}. Lane-select mem_rdata and register it. Next state DONE.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Little-endian: byte 0 = bits [7:0].
  - Extend per req_unsigned.
- ST_WR: mem_write=1, mem_wdata=wdata. Next state DONE.
- RMW_RD: mem_read=1. Register mem_rdata into a merge buffer. Next state RMW_WR.
- RMW_WR: mem_write=1. mem_wdata = the buffer with the target byte/half lane replaced by wdata[7:0]/wdata[15:0]. Next state DONE.
- DONE: resp_valid=1 for exactly one cycle. Next state IDLE.

Outputs in general:
- Memory strobes are registered, decoded from state.
- Only one of mem_read or mem_write is high in any cycle.
- Both strobes are 0 in IDLE and DONE.

Latency (acceptance edge to resp_valid cycle):
- Error: 1 cycle.
- Load and word store: 2 cycles.
- Sub-word store: 3 cycles.
- Back-to-back throughput: a new request is accepted on the edge after the DONE cycle, i.e. the cycle after resp_valid.

Boundary conditions:
- Addr 0xFF byte access is legal and targets word 0xFC, lane 3.
- Addresses do not wrap; ADDR_W spans the whole memory.
- Reset mid-operation: the in-flight request is dropped and no write occurs after reset deasserts. A partially done RMW leaves memory unmodified, because the write happens only in RMW_WR.
- req_valid held high in DONE: the request is not accepted until IDLE.

Decomposition:
Shared package dmem_pkg:
- size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- FSM state enum.
- width constants.

One natural sub-module: dmem_lane_align, which is combinational and does two jobs:
- extract and extend for loads;
- merge a lane into a word for stores.

The FSM stays in the top module.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_write for 1 cycle with mem_addr=0x10; load returns resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after acceptance.
- Byte RMW: memory word @0x20=0x11223344, sb 0xAA @0x22 -> mem_read then mem_write of 0x11AA3344; resp at +3 cycles.
- Extension: word @0x30=0x0000_80F0; lb @0x30 -> 0xFFFFFFF0; lbu @0x30 -> 0x000000F0; lh @0x30 -> 0xFFFF80F0; lhu @0x32 -> 0x00000000.
- Errors: lw @0x13, sh @0x05, size=11 -> resp_err=1 at +1 cycle, resp_rdata=0, no mem_read/mem_write pulse observed.
- Reset mid-RMW: assert reset during RMW_RD of sb @0x40 -> outputs zero immediately; word @0x40 unchanged after release; req_ready=1.
- Back-to-back: req_valid held high with 4 queued loads -> exactly one acceptance per 3 cycles, resp_valid never high for 2 consecutive cycles.
